mux_tree_out_packer: RTL and testbench
======================================

Name: mux_tree_out_packer

Overview:
- Downstream consumer of the 4-layer mux tree's serial output bit v.
- Replaces the discrete dff chain that produces the delayed select taps a_1..a_4 with a single history register, fed back to layers 2-4.
- Packs accepted v bits into WORD_W-bit words and buffers them in a small FIFO.
- Presents buffered words to the next stage over a valid/ready handshake.

Parameters:
- WORD_W, 8: bits per packed word.
- FIFO_DEPTH, 4: word FIFO entries; must be a power of 2, at least 2.
- HIST_LEN, 4: number of delayed taps of v.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- v_in  input  1  serial output bit from the mux tree final layer.
- v_valid  input  1  v_in is to be packed this cycle.
- hist  output  HIST_LEN  delayed v taps; hist[0]=a_1 ... hist[3]=a_4.
- word_data  output  WORD_W  FIFO head word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts the head word.
- fill  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky flag: a word was dropped.

Behaviour:
- Reset:
  - Asserting rst immediately clears hist, the shift register, the bit counter, the FIFO pointers, fill, word_valid and overflow.
  - word_data reads 0 while empty after reset.
  - Reset mid-word discards the partial word.
- History:
  - Shifts every clk edge, independent of v_valid.
  - hist[0]<=v_in; hist[i]<=hist[i-1].
  - hist[k] equals v_in sampled k+1 edges earlier.
- Packer:
  - 0..WORD_W-1 bit counter and WORD_W shift register.
  - On an edge with v_valid=1, v_in is placed at bit position cnt (LSB-first) and cnt increments.
  - v_valid=0 holds cnt and the partial word.
- Word completion:
  - Occurs when v_valid=1 and cnt=WORD_W-1.
  - The full word (including the current bit) is pushed on that same edge and cnt wraps to 0.
- FIFO:
  - First-word-fall-through.
  - A pushed word appears on word_data with word_valid=1 on the cycle after the completing edge. Latency from the 8th bit to word_valid is 1 cycle.
  - Pop on an edge when word_valid and word_ready are both 1.
  - word_data and word_valid are held stable while word_valid=1 and word_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Boundary conditions:
  - Push while full with a simultaneous pop: both occur and fill is unchanged.
  - Push while full without a pop: the word is dropped, FIFO contents are unchanged, and overflow is set and held until rst.
  - Pop while empty: ignored (word_ready is a don't-care while word_valid=0).
  - Push and pop when fill=1: the head advances to the new word and fill stays 1.
- Arithmetic: fill = count of pushes minus count of pops, saturating at neither end because the rules above prevent it; it never exceeds FIFO_DEPTH.

Optional Feature:
- Macro: PACK_MSB_FIRST_EN.
- When defined: bit-reversed packing; the first accepted bit lands at bit WORD_W-1 and the last at bit 0.
- When undefined: LSB-first as above.
- The history taps and the FIFO are unaffected either way.

Test Plan:
1. Reset mid-stream: assert rst after 3 valid bits with 1 word queued -> immediately hist=0, word_valid=0, fill=0, overflow=0. Then 8 valid bits 1,0,1,1,0,0,0,1 -> word_data=8'h8D (macro off) or 8'hB1 (macro on).
2. History: v_valid=0, v_in pattern 1,0,0,0,0 on successive edges -> after edge k, hist = 0001, 0010, 0100, 1000, 0000. No word is produced.
3. Gapped bits: 8 ones with v_valid deasserted for 2 cycles between each -> exactly one word 8'hFF, word_valid rising 1 cycle after the 8th valid edge, fill=1.
4. Backpressure/overflow: word_ready=0, push 5 words 8'h01..8'h05 -> fill=4 and overflow=1 after the 5th. Then word_ready=1 -> pops 01,02,03,04 and word_valid falls; overflow stays 1.
5. Full with simultaneous push+pop: fill=4, head=8'h10, a word completes on the same edge as a pop -> fill stays 4, overflow stays 0, and the new word is read 4th.
6. Wrap: stream 12 words with word_ready=1 continuously -> all 12 are received in order and fill never exceeds 1.

Source files
------------

// File: rtl/mux_tree_out_packer.sv
// mux_tree_out_packer
// Consumes the serial bit v from the final layer of the 4-layer mux tree.
// - Keeps a HIST_LEN-deep history of v. This history supplies the delayed
//   select taps a_1..a_4 that feed back into layers 2-4.
// - Packs accepted bits into WORD_W-bit words.
// - Queues finished words in a first-word-fall-through FIFO, read out over a
//   valid/ready handshake.
// Build option: define PACK_MSB_FIRST_EN to place the first accepted bit at
// bit WORD_W-1 instead of bit 0. The history taps and the FIFO behave the same
// either way.
module mux_tree_out_packer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int HIST_LEN   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          v_in,
    input  logic                          v_valid,
    output logic [HIST_LEN-1:0]           hist,
    output logic [WORD_W-1:0]             word_data,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          overflow
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int FILL_W = AW + 1;
    localparam int CW     = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    // History taps
    logic [HIST_LEN-1:0] hist_reg;
    logic [HIST_LEN-1:0] hist_next;

    // Packer state
    logic [CW-1:0]       cnt_reg;
    logic [CW-1:0]       cnt_next;
    logic [WORD_W-1:0]   shreg_reg;
    logic [WORD_W-1:0]   shreg_next;
    logic [CW-1:0]       bit_idx;
    logic                word_complete;

    // FIFO state
    logic [WORD_W-1:0]   mem_reg [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_reg;
    logic [AW-1:0]       rd_ptr_reg;
    logic [FILL_W-1:0]   fill_reg;
    logic [FILL_W-1:0]   fill_next;
    logic                overflow_reg;
    logic                fifo_full;
    logic                pop;
    logic                push_ok;
    logic                push_drop;

    // Tap i takes the previous value of tap i-1; tap 0 takes the live bit.
    assign hist_next[0] = v_in;
    generate
        for (genvar gi = 1; gi < HIST_LEN; gi++) begin : g_hist_tap
            assign hist_next[gi] = hist_reg[gi-1];
        end
    endgenerate

    // History shifts on every edge, whether or not the bit is being packed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_reg <= '0;
        end else begin
            hist_reg <= hist_next;
        end
    end

    // Target bit position for the incoming bit, set by the packing order
`ifdef PACK_MSB_FIRST_EN
    assign bit_idx = CW'(WORD_W - 1) - cnt_reg;
`else
    assign bit_idx = cnt_reg;
`endif

    assign word_complete = v_valid && (cnt_reg == CW'(WORD_W - 1));

    // Insert the current bit and advance the counter.
    // shreg_next includes the current bit, so it is the word pushed on a
    // completing edge.
    always_comb begin
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        if (v_valid) begin
            shreg_next[bit_idx] = v_in;
            cnt_next            = word_complete ? '0 : cnt_reg + CW'(1);
        end
    end

    // Packer registers. The partial word is cleared once a word completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg   <= '0;
            shreg_reg <= '0;
        end else begin
            cnt_reg   <= cnt_next;
            shreg_reg <= word_complete ? '0 : shreg_next;
        end
    end

    // FIFO control
    // - A full FIFO still accepts a push when a pop happens on the same edge.
    //   In that case the write lands in the slot being vacated.
    // - A push into a full FIFO with no pop is dropped.
    assign fifo_full = (fill_reg == FILL_W'(FIFO_DEPTH));
    assign pop       = word_valid && word_ready;
    assign push_ok   = word_complete && (!fifo_full || pop);
    assign push_drop = word_complete && fifo_full && !pop;

    // Occupancy update for every push/pop combination
    always_comb begin
        fill_next = fill_reg;
        case ({push_ok, pop})
            2'b10:   fill_next = fill_reg + FILL_W'(1);
            2'b01:   fill_next = fill_reg - FILL_W'(1);
            default: fill_next = fill_reg;
        endcase
    end

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            fill_reg <= fill_next;
            if (push_drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Word storage. No reset is needed: the output is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= shreg_next;
        end
    end

    assign word_valid = (fill_reg != '0);
    assign word_data  = word_valid ? mem_reg[rd_ptr_reg] : '0;
    assign fill       = fill_reg;
    assign overflow   = overflow_reg;
    assign hist       = hist_reg;

endmodule

// File: tb/tb_mux_tree_out_packer.sv
// Directed testbench for mux_tree_out_packer.
// Covers reset, the history taps, gapped packing, backpressure and overflow,
// full-FIFO push+pop, and pointer wrap.
module tb_mux_tree_out_packer;

    localparam int WORD_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int HIST_LEN   = 4;

    logic                               clk;
    logic                               rst;
    logic                               v_in;
    logic                               v_valid;
    logic [HIST_LEN-1:0]                hist;
    logic [WORD_W-1:0]                  word_data;
    logic                               word_valid;
    logic                               word_ready;
    logic [$clog2(FIFO_DEPTH):0]        fill;
    logic                               overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic        mon_en = 1'b0;
    logic [7:0]  rx_q[$];

    mux_tree_out_packer #(
        .WORD_W    (WORD_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .HIST_LEN  (HIST_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .v_in      (v_in),
        .v_valid   (v_valid),
        .hist      (hist),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .fill      (fill),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison; print a single line when it mismatches
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid bit for a single edge
    task automatic send_bit(input logic b);
        v_in    = b;
        v_valid = 1'b1;
        tick();
        v_valid = 1'b0;
    endtask

    // Send bits in the order that makes the packed word equal w
    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < WORD_W; i++) begin
`ifdef PACK_MSB_FIRST_EN
            send_bit(w[WORD_W-1-i]);
`else
            send_bit(w[i]);
`endif
        end
    endtask

    // Bit of w that goes out at position i of the send order
    function automatic logic order_bit(input logic [7:0] w, input int i);
`ifdef PACK_MSB_FIRST_EN
        return w[WORD_W-1-i];
`else
        return w[i];
`endif
    endfunction

    // Wrap-test monitor: records every accepted word and checks occupancy
    always @(negedge clk) begin
        if (mon_en) begin
            check("wrap_fill_le1", {31'd0, (fill <= 1)}, 32'd1);
            if (word_valid && word_ready) rx_q.push_back(word_data);
        end
    end

    initial begin
        logic [7:0] t1_bits;
        logic [7:0] t1_exp;
        logic [7:0] w5;

        rst = 1'b1; v_in = 1'b0; v_valid = 1'b0; word_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_hist",  32'(hist), 32'h0);
        check("rst_valid", 32'(word_valid), 32'h0);
        check("rst_fill",  32'(fill), 32'h0);
        check("rst_ovf",   32'(overflow), 32'h0);
        check("rst_data",  32'(word_data), 32'h0);
        $display("txn reset: hist=%0h fill=%0d", hist, fill);

        // 1. Async reset mid-stream with one word queued and a partial word
        send_word(8'h5A);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        check("t1_pre_fill", 32'(fill), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("t1_hist",  32'(hist), 32'h0);
        check("t1_valid", 32'(word_valid), 32'h0);
        check("t1_fill",  32'(fill), 32'h0);
        check("t1_ovf",   32'(overflow), 32'h0);
        #2 rst = 1'b0;
        t1_bits = 8'b1000_1101;
`ifdef PACK_MSB_FIRST_EN
        t1_exp = 8'hB1;
`else
        t1_exp = 8'h8D;
`endif
        for (int i = 0; i < 8; i++) begin
            send_bit(t1_bits[i]);
            if (i == 6) check("t1_no_early_word", 32'(word_valid), 32'h0);
        end
        check("t1_valid_after", 32'(word_valid), 32'h1);
        check("t1_data", 32'(word_data), 32'(t1_exp));
        $display("txn t1: word=%0h", word_data);
        word_ready = 1'b1; tick(); word_ready = 1'b0;
        check("t1_popped", 32'(fill), 32'h0);

        // 2. History taps with v_valid low
        v_valid = 1'b0; v_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_h;
            v_in = (k == 0);
            tick();
            exp_h = (k < 4) ? 4'(1 << k) : 4'h0;
            check("t2_hist", 32'(hist), 32'(exp_h));
            $display("txn t2: edge %0d hist=%b", k, hist);
        end
        check("t2_no_word", 32'(word_valid), 32'h0);

        // 3. Gapped ones
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            if (i == 7) begin
                check("t3_valid", 32'(word_valid), 32'h1);
                check("t3_data",  32'(word_data), 32'hFF);
                check("t3_fill",  32'(fill), 32'd1);
            end else begin
                check("t3_no_valid", 32'(word_valid), 32'h0);
                tick(); tick();
            end
        end
        $display("txn t3: word=%0h fill=%0d", word_data, fill);
        word_ready = 1'b1; tick(); word_ready = 1'b0;

        // 4. Backpressure and overflow
        for (int i = 1; i <= 5; i++) begin
            send_word(8'(i));
            if (i == 4) begin
                check("t4_fill4", 32'(fill), 32'd4);
                check("t4_no_ovf", 32'(overflow), 32'h0);
            end
        end
        check("t4_fill_full", 32'(fill), 32'd4);
        check("t4_ovf", 32'(overflow), 32'h1);
        word_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t4_pop_data", 32'(word_data), 32'(i));
            $display("txn t4: pop %0h", word_data);
            tick();
        end
        word_ready = 1'b0;
        check("t4_empty", 32'(word_valid), 32'h0);
        check("t4_ovf_sticky", 32'(overflow), 32'h1);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check("t4_ovf_cleared", 32'(overflow), 32'h0);

        // 5. Full FIFO, a push completes on the same edge as a pop
        for (int i = 0; i < 4; i++) send_word(8'h10 + 8'(i));
        check("t5_fill", 32'(fill), 32'd4);
        check("t5_head", 32'(word_data), 32'h10);
        w5 = 8'h14;
        for (int i = 0; i < 7; i++) send_bit(order_bit(w5, i));
        v_in = order_bit(w5, 7); v_valid = 1'b1; word_ready = 1'b1;
        tick();
        v_valid = 1'b0; word_ready = 1'b0;
        check("t5_fill_same", 32'(fill), 32'd4);
        check("t5_no_ovf", 32'(overflow), 32'h0);
        word_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t5_order", 32'(word_data), 32'(8'h10 + 8'(i)));
            $display("txn t5: pop %0h", word_data);
            tick();
        end
        word_ready = 1'b0;
        check("t5_empty", 32'(fill), 32'h0);

        // 6. Stream 12 words with continuous ready to wrap the pointers
        rx_q.delete();
        word_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 12; i++) send_word(8'h30 + 8'(i * 7));
        tick(); tick(); tick();
        mon_en = 1'b0;
        word_ready = 1'b0;
        check("t6_count", 32'(rx_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] got;
            got = (i < rx_q.size()) ? rx_q[i] : 8'h00;
            check("t6_word", 32'(got), 32'(8'h30 + 8'(i * 7)));
            $display("txn t6: word %0d = %0h", i, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
